// File: rtl/data_mem_param_if.sv
// Bus bundle for data_mem_param: port A load/store, port B registered reader, status.
// The master drives requests and the slave (the memory) returns data and status.
interface data_mem_param_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          MemWriteEn;
  logic [AW-1:0] DataAddress;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          RdEnB;
  logic [AW-1:0] RdAddrB;
  logic [DW-1:0] RdDataB;
  logic          RdValidB;
  logic          Busy;
  logic          AddrErr;

  modport master (
    output MemWriteEn, DataAddress, DataIn, RdEnB, RdAddrB,
    input  DataOut, RdDataB, RdValidB, Busy, AddrErr
  );

  modport slave (
    input  MemWriteEn, DataAddress, DataIn, RdEnB, RdAddrB,
    output DataOut, RdDataB, RdValidB, Busy, AddrErr
  );
endinterface

// File: rtl/data_mem_param.sv
// Parametrised data memory: clear sequencer after reset, combinational port A, registered port B,
// sticky out-of-range flag. Define DATA_MEM_BYPASS_EN for write-first forwarding on A/B collisions.
module data_mem_param #(
  parameter int             DW       = 8,
  parameter int             AW       = 8,
  parameter int             DEPTH    = 256,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  data_mem_param_if.slave  bus,
  output logic [DW-1:0]    core_out [DEPTH]
);

  localparam int            IW     = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_W  = (AW+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state;
  state_t        nextState;
  logic [AW:0]   ClrAddr;
  logic [DW-1:0] mem [DEPTH];

  logic          aInRange;
  logic          bInRange;
  logic [IW-1:0] aIdx;
  logic [IW-1:0] bIdx;
  logic [IW-1:0] clrIdx;
  logic [DW-1:0] bReadData;

  // Addresses are widened by one bit so DEPTH == 2**AW compares without overflow.
  assign aInRange = {1'b0, bus.DataAddress} < DEPTH_W;
  assign bInRange = {1'b0, bus.RdAddrB} < DEPTH_W;
  assign aIdx     = bus.DataAddress[IW-1:0];
  assign bIdx     = bus.RdAddrB[IW-1:0];
  assign clrIdx   = ClrAddr[IW-1:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= CLEAR;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    bus.Busy  = 1'b0;
    case (state)
      CLEAR: begin
        bus.Busy = 1'b1;
        if (ClrAddr == LAST_W) nextState = READY;
      end
      READY: nextState = READY;
      default: nextState = CLEAR;
    endcase
  end

  // The array has no reset; the sequencer fills it with INIT_VAL once Reset is released.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == CLEAR)                       mem[clrIdx] <= INIT_VAL;
      else if (bus.MemWriteEn && aInRange)      mem[aIdx]   <= bus.DataIn;
    end
  end

  always_comb begin
    bReadData = '0;
    if (bInRange) begin
`ifdef DATA_MEM_BYPASS_EN
      if (bus.MemWriteEn && aInRange && (bus.DataAddress == bus.RdAddrB))
        bReadData = bus.DataIn;
      else
        bReadData = mem[bIdx];
`else
      bReadData = mem[bIdx];
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ClrAddr      <= '0;
      bus.RdDataB  <= '0;
      bus.RdValidB <= 1'b0;
      bus.AddrErr  <= 1'b0;
    end else begin
      bus.RdValidB <= 1'b0;
      if (state == CLEAR) begin
        ClrAddr <= ClrAddr + 1'b1;
      end else begin
        if (bus.RdEnB) begin
          bus.RdDataB  <= bReadData;
          bus.RdValidB <= 1'b1;
        end
        if ((bus.MemWriteEn && !aInRange) || (bus.RdEnB && !bInRange))
          bus.AddrErr <= 1'b1;
      end
    end
  end

  assign bus.DataOut = aInRange ? mem[aIdx] : '0;
  assign core_out    = mem;

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench for data_mem_param: a full-range instance (DEPTH=256) and a short one (DEPTH=200)
// for the out-of-range paths; port B responses are checked by a queue-based monitor.
module tb_data_mem_param;

  logic Clk;
  logic rst0;
  logic rst1;
  logic [7:0] core0 [256];
  logic [7:0] core1 [200];

  int tests = 0;
  int failCount = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  data_mem_param_if #(.DW(8), .AW(8)) bus0 ();
  data_mem_param_if #(.DW(8), .AW(8)) bus1 ();

  data_mem_param #(.DW(8), .AW(8), .DEPTH(256), .INIT_VAL(8'hA5)) dut0 (
    .Clk(Clk), .Reset(rst0), .bus(bus0.slave), .core_out(core0)
  );

  data_mem_param #(.DW(8), .AW(8), .DEPTH(200), .INIT_VAL(8'h5A)) dut1 (
    .Clk(Clk), .Reset(rst1), .bus(bus1.slave), .core_out(core1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; holds the vector across one posedge, then idles the enables.
  task automatic applyStimulus(input int d, input logic we, input logic [7:0] addr, input logic [7:0] data,
                               input logic re, input logic [7:0] raddr, input logic [7:0] expB);
    if (d == 0) begin
      bus0.MemWriteEn = we; bus0.DataAddress = addr; bus0.DataIn = data;
      bus0.RdEnB = re; bus0.RdAddrB = raddr;
      if (re) q0.push_back(expB);
    end else begin
      bus1.MemWriteEn = we; bus1.DataAddress = addr; bus1.DataIn = data;
      bus1.RdEnB = re; bus1.RdAddrB = raddr;
      if (re) q1.push_back(expB);
    end
    @(negedge Clk);
    if (d == 0) begin bus0.MemWriteEn = 1'b0; bus0.RdEnB = 1'b0; end
    else        begin bus1.MemWriteEn = 1'b0; bus1.RdEnB = 1'b0; end
  endtask

  task automatic countBusy(input int d, output int cnt);
    cnt = 0;
    while (((d == 0) ? bus0.Busy : bus1.Busy) && cnt < 1000) begin
      @(posedge Clk);
      #1;
      cnt++;
    end
  endtask

  // Scoreboard monitor: every RdValidB pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (bus0.RdValidB) begin
      if (q0.size() == 0) begin
        tests++; failCount++;
        $display("[TB] FAIL b0_unexpected_valid: got RdValidB=1 RdDataB=%0h, expected no pulse", bus0.RdDataB);
      end else checkOutput("b0_rddata", 32'(bus0.RdDataB), 32'(q0.pop_front()));
    end
    if (bus1.RdValidB) begin
      if (q1.size() == 0) begin
        tests++; failCount++;
        $display("[TB] FAIL b1_unexpected_valid: got RdValidB=1 RdDataB=%0h, expected no pulse", bus1.RdDataB);
      end else checkOutput("b1_rddata", 32'(bus1.RdDataB), 32'(q1.pop_front()));
    end
  end

  initial begin
    int cnt;
    int bad;
    rst0 = 1'b0; rst1 = 1'b0;
    bus0.MemWriteEn = 0; bus0.DataAddress = 0; bus0.DataIn = 0; bus0.RdEnB = 0; bus0.RdAddrB = 0;
    bus1.MemWriteEn = 0; bus1.DataAddress = 0; bus1.DataIn = 0; bus1.RdEnB = 0; bus1.RdAddrB = 0;
    #2 rst0 = 1'b1; rst1 = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(bus0.Busy), 1);
    checkOutput("rst_validB", 32'(bus0.RdValidB), 0);
    checkOutput("rst_rddataB", 32'(bus0.RdDataB), 0);
    checkOutput("rst_addrerr", 32'(bus0.AddrErr), 0);

    // First clear interrupted at cycle 100 by a reset pulse.
    @(negedge Clk); rst0 = 1'b0;
    repeat (100) @(posedge Clk);
    @(negedge Clk); rst0 = 1'b1;
    #1 checkOutput("midclear_busy", 32'(bus0.Busy), 1);
    // Writes and reads requested during the clear must be ignored.
    bus0.MemWriteEn = 1'b1; bus0.DataAddress = 8'h05; bus0.DataIn = 8'hFF;
    bus0.RdEnB = 1'b1; bus0.RdAddrB = 8'h03;
    @(negedge Clk); rst0 = 1'b0;
    countBusy(0, cnt);
    bus0.MemWriteEn = 1'b0; bus0.RdEnB = 1'b0;
    checkOutput("busy_edges_256", 32'(cnt), 256);
    checkOutput("gated_mem5", 32'(core0[5]), 32'h A5);
    bad = 0;
    for (int i = 0; i < 256; i++) if (core0[i] !== 8'hA5) bad++;
    checkOutput("clear_all_A5", 32'(bad), 0);
    checkOutput("clear_addrerr", 32'(bus0.AddrErr), 0);

    // Basic port A write with old-then-new DataOut, then port B read.
    @(negedge Clk);
    bus0.DataAddress = 8'h10;
    #1 checkOutput("a_old_10", 32'(bus0.DataOut), 32'hA5);
    applyStimulus(0, 1, 8'h10, 8'h3C, 0, 8'h00, 8'h00);
    #1 checkOutput("a_new_10", 32'(bus0.DataOut), 32'h3C);
    applyStimulus(0, 0, 8'h10, 8'h00, 1, 8'h10, 8'h3C);
    applyStimulus(0, 0, 8'h10, 8'h00, 0, 8'h10, 8'h00);

    // Same-address collision, then confirm the write landed.
`ifdef DATA_MEM_BYPASS_EN
    applyStimulus(0, 1, 8'h20, 8'h77, 1, 8'h20, 8'h77);
`else
    applyStimulus(0, 1, 8'h20, 8'h77, 1, 8'h20, 8'hA5);
`endif
    applyStimulus(0, 0, 8'h20, 8'h00, 1, 8'h20, 8'h77);

    // Different-address write and read together, plus the top address.
    applyStimulus(0, 1, 8'h30, 8'h42, 1, 8'h10, 8'h3C);
    applyStimulus(0, 1, 8'hFF, 8'hC3, 1, 8'h30, 8'h42);
    applyStimulus(0, 0, 8'hFF, 8'h00, 1, 8'hFF, 8'hC3);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 8'h00, 8'hA5);
    repeat (2) @(negedge Clk);
    checkOutput("full_addrerr", 32'(bus0.AddrErr), 0);

    // Short instance: out-of-range behaviour.
    rst1 = 1'b0;
    countBusy(1, cnt);
    checkOutput("busy_edges_200", 32'(cnt), 200);
    @(negedge Clk);
    bus1.DataAddress = 8'd210;
    #1 checkOutput("oor_dataout", 32'(bus1.DataOut), 0);
    @(negedge Clk);
    checkOutput("oor_read_no_err", 32'(bus1.AddrErr), 0);
    bus1.DataAddress = 8'd199;
    #1 checkOutput("last_dataout", 32'(bus1.DataOut), 32'h5A);
    @(negedge Clk);
    applyStimulus(1, 1, 8'd210, 8'h11, 0, 8'd0, 8'h00);
    checkOutput("oor_write_err", 32'(bus1.AddrErr), 1);
    bad = 0;
    for (int i = 0; i < 200; i++) if (core1[i] !== 8'h5A) bad++;
    checkOutput("oor_no_change", 32'(bad), 0);
    applyStimulus(1, 1, 8'd7, 8'h33, 1, 8'd199, 8'h5A);
    applyStimulus(1, 0, 8'd7, 8'h00, 1, 8'd7, 8'h33);
    applyStimulus(1, 0, 8'd0, 8'h00, 1, 8'd210, 8'h00);
    applyStimulus(1, 0, 8'd0, 8'h00, 1, 8'd200, 8'h00);
    repeat (2) @(negedge Clk);
    checkOutput("err_sticky", 32'(bus1.AddrErr), 1);
    rst1 = 1'b1;
    #1 checkOutput("err_cleared", 32'(bus1.AddrErr), 0);
    checkOutput("rst1_busy", 32'(bus1.Busy), 1);

    repeat (2) @(negedge Clk);
    checkOutput("sb_drain0", 32'(q0.size()), 0);
    checkOutput("sb_drain1", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failCount);
    $finish;
  end

endmodule
